// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor.
// A direct-mapped BTB/BHT with 2-bit saturating counters. When the BTB misses,
// a static BTFNT fallback is used instead.
// Lookup is combinational on pcF/instrF and reads registered state only.
// The table and the statistics are updated from execute-stage branch resolution.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   pcF, instrF       - fetch PC and the instruction fetched at that PC
//   hitF              - BTB entry valid and tag match for pcF
//   predict_takenF    - predicted taken
//   predict_targetF   - predicted next PC
//   update_*          - resolved conditional branch from execute
//   branch_total/taken/correct - wrapping 32-bit branch statistics
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic [31:0] instrF,
  output logic        hitF,
  output logic        predict_takenF,
  output logic [31:0] predict_targetF,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_pred_taken,
  output logic [31:0] branch_total,
  output logic [31:0] branch_taken,
  output logic [31:0] branch_correct
);

  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][TAG_W-1:0] tag;
  logic [ENTRIES-1:0][31:0]      target;
  logic [ENTRIES-1:0][1:0]       ctr;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             is_br;
  logic [31:0]      imm_b;
  logic [31:0]      pc_plus4;

  assign idx_f    = pcF[IDX_W+1:2];
  assign tag_f    = pcF[31:IDX_W+2];
  assign is_br    = (instrF[6:0] == 7'b1100011);
  assign imm_b    = {{20{instrF[31]}}, instrF[7], instrF[30:25], instrF[11:8], 1'b0};
  assign pc_plus4 = pcF + 32'd4;
  assign hitF     = valid[idx_f] && (tag[idx_f] == tag_f);

  always_comb begin
    predict_takenF  = 1'b0;
    predict_targetF = pc_plus4;
    if (hitF) begin
      predict_takenF = ctr[idx_f][1];
      if (predict_takenF) predict_targetF = target[idx_f];
    end else begin
      // Backward branches (negative offset) are predicted taken.
      predict_takenF = is_br && imm_b[31];
      if (predict_takenF) predict_targetF = pcF + imm_b;
    end
  end

  // ---------------- update ----------------
  logic [IDX_W-1:0] idx_u;
  logic [TAG_W-1:0] tag_u;
  logic             hit_u;

  assign idx_u = update_pc[IDX_W+1:2];
  assign tag_u = update_pc[31:IDX_W+2];
  assign hit_u = valid[idx_u] && (tag[idx_u] == tag_u);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (update_valid) begin
      if (hit_u) begin
        if (update_taken) begin
          target[idx_u] <= update_target;
          if (ctr[idx_u] != 2'b11) ctr[idx_u] <= ctr[idx_u] + 2'd1;
        end else if (ctr[idx_u] != 2'b00) begin
          ctr[idx_u] <= ctr[idx_u] - 2'd1;
        end
      end else begin
        // Allocate or replace: start weakly biased toward the observed outcome.
        valid[idx_u]  <= 1'b1;
        tag[idx_u]    <= tag_u;
        target[idx_u] <= update_target;
        ctr[idx_u]    <= update_taken ? 2'b10 : 2'b01;
      end
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_total   <= '0;
      branch_taken   <= '0;
      branch_correct <= '0;
    end else if (update_valid) begin
      branch_total   <= branch_total + 32'd1;
      branch_taken   <= branch_taken + {31'd0, update_taken};
      branch_correct <= branch_correct + {31'd0, (update_pred_taken == update_taken)};
    end
  end

  // Bits that carry no information for prediction.
  logic unused;
  assign unused = ^{instrF[24:12], pcF[1:0], update_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF, instrF;
  logic        hitF, predict_takenF;
  logic [31:0] predict_targetF;
  logic        update_valid, update_taken, update_pred_taken;
  logic [31:0] update_pc, update_target;
  logic [31:0] branch_total, branch_taken, branch_correct;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF),
    .hitF(hitF), .predict_takenF(predict_takenF), .predict_targetF(predict_targetF),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .branch_total(branch_total), .branch_taken(branch_taken), .branch_correct(branch_correct)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, instr;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic        ehit, etak;
    logic [31:0] etgt;
  } vec_t;

  vec_t tbl[9];

  // ---------------- behavioural model for random phase ----------------
  // Each entry remembers which branch (by word address) it holds and an
  // integer confidence 0..3; taken prediction when confidence >= 2.
  bit          m_val[ENTRIES];
  logic [31:0] m_word[ENTRIES];
  logic [31:0] m_tgt[ENTRIES];
  int          m_conf[ENTRIES];
  logic [31:0] m_total, m_taken, m_correct;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] branch_offset(input logic [31:0] ins);
    int v;
    v = ins[31] * 4096 + ins[7] * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    if (ins[31]) v = v - 8192;
    return 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_val[i] = 0; m_word[i] = 0; m_tgt[i] = 0; m_conf[i] = 1;
    end
    m_total = 0; m_taken = 0; m_correct = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, input logic [31:0] ins,
                               output logic hit, output logic tak, output logic [31:0] tgt);
    int s;
    s   = slot(pc);
    hit = m_val[s] && (m_word[s] == (pc >> 2));
    if (hit) begin
      tak = (m_conf[s] >= 2);
      tgt = tak ? m_tgt[s] : pc + 4;
    end else begin
      tak = (ins[6:0] == 7'h63) && ins[31];
      tgt = tak ? pc + branch_offset(ins) : pc + 4;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic t,
                              input logic [31:0] tgt, input logic pt);
    int s;
    s = slot(pc);
    if (m_val[s] && m_word[s] == (pc >> 2)) begin
      if (t) begin
        m_tgt[s] = tgt;
        m_conf[s] = (m_conf[s] + 1 > 3) ? 3 : m_conf[s] + 1;
      end else begin
        m_conf[s] = (m_conf[s] - 1 < 0) ? 0 : m_conf[s] - 1;
      end
    end else begin
      m_val[s] = 1; m_word[s] = pc >> 2; m_tgt[s] = tgt; m_conf[s] = t ? 2 : 1;
    end
    m_total   = m_total + 1;
    m_taken   = m_taken + 32'(t);
    m_correct = m_correct + 32'(t == pt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return {r[31:2], 2'b00};
    return {20'd0, r[11:10], 4'd0, r[5:2], 2'b00};
  endfunction

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic pt);
    update_valid = v; update_pc = pc; update_taken = t;
    update_target = tgt; update_pred_taken = pt;
  endtask

  initial begin
    logic        eh, et;
    logic [31:0] eg, r;
    bit          tv[5], pv[5];

    // pc, instr, uv, upc, ut, utgt, upt, ehit, etak, etgt
    tbl[0] = '{32'h20, 32'hFE000CE3, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h18};
    tbl[1] = '{32'h20, 32'h00000863, 1'b1, 32'h40, 1'b1, 32'h80,  1'b0, 1'b0, 1'b0, 32'h24};
    tbl[2] = '{32'h40, 32'h00000013, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h80};
    tbl[3] = '{32'h40, 32'h00000013, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h44};
    tbl[4] = '{32'h40, 32'h00000013, 1'b1, 32'h40, 1'b1, 32'h80,  1'b0, 1'b1, 1'b0, 32'h44};
    tbl[5] = '{32'h40, 32'h00000013, 1'b1, 32'h40, 1'b1, 32'h80,  1'b0, 1'b1, 1'b0, 32'h44};
    tbl[6] = '{32'h40, 32'h00000013, 1'b1, 32'h80, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h80};
    tbl[7] = '{32'h40, 32'h00000013, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h44};
    tbl[8] = '{32'h80, 32'h00000013, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100};

    rst = 1'b1; pcF = 32'h20; instrF = 32'hFE000CE3;
    set_upd(0, 0, 0, 0, 0);
    #1;
    chk("reset_hit", 32'(hitF), 0);
    chk("reset_total", branch_total, 0);
    chk("reset_btfnt_target", predict_targetF, 32'h18);
    @(negedge clk); rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pcF = tbl[i].pc; instrF = tbl[i].instr;
      set_upd(tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, tbl[i].upt);
      #1;
      chk($sformatf("tbl%0d_hit", i), 32'(hitF), 32'(tbl[i].ehit));
      chk($sformatf("tbl%0d_taken", i), 32'(predict_takenF), 32'(tbl[i].etak));
      chk($sformatf("tbl%0d_target", i), predict_targetF, tbl[i].etgt);
    end
    @(negedge clk); update_valid = 1'b0;

    // ---- statistics sequence ----
    rst = 1'b1; #1; rst = 1'b0;
    tv = '{1, 0, 1, 0, 0}; pv = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_upd(1, 32'h40, tv[i], 32'h80, pv[i]);
    end
    @(negedge clk); update_valid = 1'b0; pcF = 32'h40; instrF = 32'h13;
    #1;
    chk("stats_total", branch_total, 5);
    chk("stats_taken", branch_taken, 2);
    chk("stats_correct", branch_correct, 3);
    repeat (2) @(negedge clk);
    #1;
    chk("stats_idle_total", branch_total, 5);
    chk("stats_idle_correct", branch_correct, 3);
    chk("pre_reset_hit", 32'(hitF), 1);

    // ---- asynchronous reset mid-cycle, update during reset dropped ----
    @(negedge clk);
    set_upd(1, 32'h40, 1, 32'h80, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_total", branch_total, 0);
    chk("async_rst_taken", branch_taken, 0);
    chk("async_rst_correct", branch_correct, 0);
    chk("async_rst_hit", 32'(hitF), 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_hit", 32'(hitF), 0);
    chk("post_rst_total", branch_total, 0);
    @(posedge clk); #1;
    chk("first_update_total", branch_total, 1);
    chk("first_update_hit", 32'(hitF), 1);
    @(negedge clk); update_valid = 1'b0;

    // ---- randomized phase ----
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      pcF = rand_pc();
      r = $urandom;
      instrF = ($urandom_range(0, 1) == 1) ? {r[31:7], 7'h63} : r;
      r = $urandom;
      set_upd($urandom_range(0, 2) != 0,
              ($urandom_range(0, 3) == 0) ? pcF : rand_pc(),
              r[0], {r[31:2], 2'b00} ^ 32'h5A5A0000, r[1]);
      #1;
      model_predict(pcF, instrF, eh, et, eg);
      chk("rnd_hit", 32'(hitF), 32'(eh));
      chk("rnd_taken", 32'(predict_takenF), 32'(et));
      chk("rnd_target", predict_targetF, eg);
      chk("rnd_total", branch_total, m_total);
      chk("rnd_taken_cnt", branch_taken, m_taken);
      chk("rnd_correct", branch_correct, m_correct);
      @(posedge clk);
      if (update_valid) model_update(update_pc, update_taken, update_target, update_pred_taken);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor; sits directly upstream of decode.
- Each cycle it looks up pcF and instrF and drives the predicted next-PC into the fetch PC mux.
- Combines a direct-mapped BTB/BHT of 2-bit saturating counters with a BTFNT fallback when the BTB misses.
- Updated from execute-stage branch resolution; keeps hardware branch statistics (total/taken/correct).

Parameters:
ENTRIES, 16, number of BTB/BHT entries; power of two, at least 2.
IDX_W, $clog2(ENTRIES), index width.
TAG_W, 30-IDX_W, tag width (pc[31:IDX_W+2]).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous reset, active-high.
pcF  in  32  fetch PC, word aligned.
instrF  in  32  instruction fetched at pcF.
hitF  out  1  BTB entry valid and tag match for pcF.
predict_takenF  out  1  predicted taken.
predict_targetF  out  32  predicted next PC.
update_valid  in  1  a conditional branch resolved in E this cycle.
update_pc  in  32  PC of the resolved branch.
update_taken  in  1  actual outcome (PCSrcE).
update_target  in  32  actual taken target (PCTargetE).
update_pred_taken  in  1  prediction carried down the pipe with that branch.
branch_total  out  32  resolved-branch count.
branch_taken  out  32  actually-taken count.
branch_correct  out  32  correct-prediction count.

Behaviour:
- Table per entry: valid (1b), tag (TAG_W), target (32b), ctr (2b). idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- Lookup is combinational, zero latency, and reads registered table state only.
- hitF = valid[idx] && tag[idx] == pcF tag.
- On hit: predict_takenF = ctr[1]; predict_targetF = predict_takenF ? target[idx] : pcF+4.
- On miss, BTFNT fallback:
  - is_br = instrF[6:0] == 7'b1100011.
  - immB = {{20{instrF[31]}}, instrF[7], instrF[30:25], instrF[11:8], 1'b0}.
  - predict_takenF = is_br && immB[31]; predict_targetF = taken ? pcF+immB : pcF+4.
- All additions are 32-bit modulo 2^32.
- Update, on the rising edge when update_valid=1:
  - Hit on update_pc: ctr saturating increment if taken, decrement if not; range 00..11, no wrap. If taken, target <= update_target.
  - Miss: allocate or replace the entry. valid<=1, tag<=update tag, target<=update_target, ctr <= update_taken ? 2'b10 : 2'b01.
  - update_valid=0: table unchanged. update_pc is never checked for branch-ness; the pipeline asserts update_valid only for B-type.
- Statistics, on the same edge as an update:
  - branch_total += 1.
  - branch_taken += update_taken.
  - branch_correct += (update_pred_taken == update_taken).
  - All three wrap modulo 2^32.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update state; the new state is visible the next cycle (no bypass).
- Reset (async, any time): all valid<=0, ctr<=2'b01, target<=0, tag<=0, stats<=0.
  - Outputs follow immediately: hitF=0, predict_takenF/target per BTFNT on the current inputs, branch_* = 0.
  - An update coinciding with reset is dropped. The first update is accepted on the first rising edge after rst deasserts.
- No stall input: the predictor is stateless on the lookup side. Fetch stalls simply re-present the same pcF.

Test Plan:
1. After reset, pcF=0x20, instrF=0xFE000CE3 (beq x0,x0,-8) -> hitF=0, predict_takenF=1, predict_targetF=0x18. Then instrF=0x00000863 (beq +16) -> predict_takenF=0, target=0x24.
2. update pc=0x40, taken=1, target=0x80. Next cycle pcF=0x40, instrF=0x00000013 -> hitF=1, taken=1, target=0x80. Two not-taken updates -> ctr=00, predict 0, target 0x44. One taken update -> ctr=01, still predict 0.
3. Same-cycle update and lookup on pcF=0x40 with the entry at ctr=01 and a taken update -> that cycle predict 0; next cycle predict 1.
4. Alias (ENTRIES=16): entry at 0x40 valid; update pc=0x80 (same idx 0, different tag) taken -> lookup 0x40 now hitF=0; lookup 0x80 hitF=1, ctr=10.
5. Stats: 5 updates (taken,pred) = (1,1),(0,0),(1,0),(0,1),(0,0) -> branch_total=5, branch_taken=2, branch_correct=3. update_valid=0 cycles leave the counts unchanged.
6. Assert rst asynchronously mid-cycle after test 5 -> branch_*=0 and hitF=0 before the next edge. An update asserted during reset is ignored; lookup of 0x40 after release -> hitF=0.
